// File: rtl/debug_target.sv
// debug_target
// CPU-side responder for the 2-bit-address debug register interface.
// The debug controller writes CMD/ADDR/DATA, raises req, and this block
// executes the command against the core (halt/run/step/GPR access) or the
// memory bus, then finishes with a single-cycle ack pulse.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   addr            register select: 0 CMD/STATUS, 1 ADDR, 2 DATA, 3 RESULT
//   write_data      write value, stored when wr_en is high
//   wr_en           one-cycle register write strobe
//   req             execute the latched CMD, held high until ack
//   read_data       registered read value for addr (1-cycle latency)
//   ack             one-cycle command completion pulse
//   cpu_halt_req    level, core halts while high
//   cpu_stopped     core is halted
//   cpu_step        one-cycle single-step pulse
//   cpu_step_done   one-cycle pulse when the stepped instruction retires
//   reg_sel         GPR index taken from the ADDR low bits
//   reg_wr_en       one-cycle GPR write strobe
//   reg_wr_val      GPR write value (DATA)
//   reg_rd_val      GPR read value, combinational from reg_sel
//   mem_addr        word-aligned memory address
//   mem_wr_data     memory write value (DATA)
//   mem_wr_en       write qualifier, valid while mem_access is high
//   mem_access      memory request, held until mem_ack or timeout
//   mem_ack         memory transfer complete
//   mem_rd_data     memory read value, valid with mem_ack

module debug_target #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit HALT_ON_RESET  = 1'b0,
    parameter int REG_SEL_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           addr,
    input  logic [31:0]          write_data,
    input  logic                 wr_en,
    input  logic                 req,
    output logic [31:0]          read_data,
    output logic                 ack,
    output logic                 cpu_halt_req,
    input  logic                 cpu_stopped,
    output logic                 cpu_step,
    input  logic                 cpu_step_done,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 reg_wr_en,
    output logic [31:0]          reg_wr_val,
    input  logic [31:0]          reg_rd_val,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wr_data,
    output logic                 mem_wr_en,
    output logic                 mem_access,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rd_data
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] OP_HALT  = 4'd0;
    localparam logic [3:0] OP_RUN   = 4'd1;
    localparam logic [3:0] OP_STEP  = 4'd2;
    localparam logic [3:0] OP_RDREG = 4'd3;
    localparam logic [3:0] OP_WRREG = 4'd4;
    localparam logic [3:0] OP_RDMEM = 4'd5;
    localparam logic [3:0] OP_WRMEM = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HALT,
        S_WAIT_STEP,
        S_REG,
        S_MEM,
        S_ACK
    } state_t;

    state_t            state_q;
    logic [31:0]       cmd_q;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [31:0]       result_q;
    logic              err_q;
    logic [3:0]        op_q;
    logic [31:0]       op_addr_q;
    logic [31:0]       op_data_q;
    logic [CNT_W-1:0]  tcnt_q;
    logic              ack_q;
    logic              halt_q;
    logic              step_q;
    logic              reg_wr_en_q;
    logic              mem_access_q;
    logic              mem_wr_en_q;
    logic [31:0]       read_data_d;
    logic [31:0]       read_data_q;

    // ADDR and DATA are copied at command start so that register writes
    // arriving while a command runs cannot disturb the bus/GPR outputs.
    assign reg_sel      = op_addr_q[REG_SEL_W-1:0];
    assign reg_wr_val   = op_data_q;
    assign mem_addr     = {op_addr_q[31:2], 2'b00};
    assign mem_wr_data  = op_data_q;
    assign read_data    = read_data_q;
    assign ack          = ack_q;
    assign cpu_halt_req = halt_q;
    assign cpu_step     = step_q;
    assign reg_wr_en    = reg_wr_en_q;
    assign mem_access   = mem_access_q;
    assign mem_wr_en    = mem_wr_en_q;

    always_comb begin
        read_data_d = '0;
        case (addr)
            2'd0:    read_data_d = {29'b0, err_q, (state_q != S_IDLE), cpu_stopped};
            2'd1:    read_data_d = addr_q;
            2'd2:    read_data_d = data_q;
            default: read_data_d = result_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    // Register file writes and the command FSM. Pulse outputs default low
    // each cycle and are raised only in the cycle that needs them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            op_q         <= '0;
            op_addr_q    <= '0;
            op_data_q    <= '0;
            tcnt_q       <= '0;
            ack_q        <= 1'b0;
            halt_q       <= HALT_ON_RESET;
            step_q       <= 1'b0;
            reg_wr_en_q  <= 1'b0;
            mem_access_q <= 1'b0;
            mem_wr_en_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                case (addr)
                    2'd0:    cmd_q  <= write_data;
                    2'd1:    addr_q <= write_data;
                    2'd2:    data_q <= write_data;
                    default: ;
                endcase
            end

            ack_q       <= 1'b0;
            step_q      <= 1'b0;
            reg_wr_en_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        err_q     <= 1'b0;
                        tcnt_q    <= '0;
                        op_q      <= cmd_q[3:0];
                        op_addr_q <= addr_q;
                        op_data_q <= data_q;
                        if (cmd_q[31:4] != 28'd0) begin
                            err_q   <= 1'b1;
                            state_q <= S_ACK;
                        end else begin
                            case (cmd_q[3:0])
                                OP_HALT: begin
                                    halt_q  <= 1'b1;
                                    state_q <= S_WAIT_HALT;
                                end
                                OP_RUN: begin
                                    halt_q  <= 1'b0;
                                    state_q <= S_ACK;
                                end
                                OP_STEP: begin
                                    if (cpu_stopped) begin
                                        step_q  <= 1'b1;
                                        state_q <= S_WAIT_STEP;
                                    end else begin
                                        err_q   <= 1'b1;
                                        state_q <= S_ACK;
                                    end
                                end
                                OP_RDREG: begin
                                    if (cpu_stopped) begin
                                        state_q <= S_REG;
                                    end else begin
                                        err_q   <= 1'b1;
                                        state_q <= S_ACK;
                                    end
                                end
                                OP_WRREG: begin
                                    if (cpu_stopped) begin
                                        reg_wr_en_q <= 1'b1;
                                        state_q     <= S_REG;
                                    end else begin
                                        err_q   <= 1'b1;
                                        state_q <= S_ACK;
                                    end
                                end
                                OP_RDMEM: begin
                                    mem_access_q <= 1'b1;
                                    mem_wr_en_q  <= 1'b0;
                                    state_q      <= S_MEM;
                                end
                                OP_WRMEM: begin
                                    mem_access_q <= 1'b1;
                                    mem_wr_en_q  <= 1'b1;
                                    state_q      <= S_MEM;
                                end
                                default: begin
                                    err_q   <= 1'b1;
                                    state_q <= S_ACK;
                                end
                            endcase
                        end
                    end
                end

                // A halt timeout leaves cpu_halt_req asserted on purpose.
                S_WAIT_HALT: begin
                    if (cpu_stopped) begin
                        state_q <= S_ACK;
                    end else if (tcnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        tcnt_q <= tcnt_q + CNT_W'(1);
                    end
                end

                S_WAIT_STEP: begin
                    if (cpu_step_done) begin
                        state_q <= S_ACK;
                    end else if (tcnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        tcnt_q <= tcnt_q + CNT_W'(1);
                    end
                end

                // reg_rd_val follows reg_sel, which was set up on entry here.
                S_REG: begin
                    if (op_q == OP_RDREG) begin
                        result_q <= reg_rd_val;
                    end
                    state_q <= S_ACK;
                end

                // mem_ack is checked first so it wins over a same-cycle timeout.
                S_MEM: begin
                    if (mem_ack) begin
                        if (op_q == OP_RDMEM) begin
                            result_q <= mem_rd_data;
                        end
                        mem_access_q <= 1'b0;
                        mem_wr_en_q  <= 1'b0;
                        state_q      <= S_ACK;
                    end else if (tcnt_q == CNT_LAST) begin
                        err_q        <= 1'b1;
                        mem_access_q <= 1'b0;
                        mem_wr_en_q  <= 1'b0;
                        state_q      <= S_ACK;
                    end else begin
                        tcnt_q <= tcnt_q + CNT_W'(1);
                    end
                end

                S_ACK: begin
                    ack_q   <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_target.sv
// tb_debug_target
// Randomised bench for debug_target. The bench models the core (halt
// latency, single-step latency, GPR file) and the memory (response latency,
// backing store) and predicts command results and latencies from the
// command rules directly.

module tb_debug_target;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [31:0] write_data = '0;
    logic        wr_en = 1'b0;
    logic        req = 1'b0;
    logic [31:0] read_data;
    logic        ack;
    logic        cpu_halt_req;
    logic        cpu_stopped = 1'b0;
    logic        cpu_step;
    logic        cpu_step_done = 1'b0;
    logic [3:0]  reg_sel;
    logic        reg_wr_en;
    logic [31:0] reg_wr_val;
    logic [31:0] reg_rd_val;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_en;
    logic        mem_access;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rd_data = '0;

    int checks = 0;
    int errors = 0;

    // reference register model
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_result = '0;

    // results gathered by issue()
    int r_lat, r_acks, r_macc, r_rwe, r_steps;
    bit r_addr_bad;

    debug_target #(
        .TIMEOUT_CYCLES(TO),
        .HALT_ON_RESET (1'b0),
        .REG_SEL_W     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .write_data   (write_data),
        .wr_en        (wr_en),
        .req          (req),
        .read_data    (read_data),
        .ack          (ack),
        .cpu_halt_req (cpu_halt_req),
        .cpu_stopped  (cpu_stopped),
        .cpu_step     (cpu_step),
        .cpu_step_done(cpu_step_done),
        .reg_sel      (reg_sel),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_val   (reg_wr_val),
        .reg_rd_val   (reg_rd_val),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .mem_access   (mem_access),
        .mem_ack      (mem_ack),
        .mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    // core model: stops halt_delay cycles after the halt request, retires a
    // step step_delay cycles after the step pulse
    int halt_delay = 5;
    int hcnt = 0;
    int step_delay = 1;
    int step_pend = 0;
    always @(negedge clk) begin
        cpu_step_done = 1'b0;
        if (cpu_halt_req) begin
            if (!cpu_stopped) begin
                hcnt++;
                if (hcnt >= halt_delay) cpu_stopped = 1'b1;
            end
        end else begin
            cpu_stopped = 1'b0;
            hcnt = 0;
        end
        if (step_pend > 0) begin
            step_pend--;
            if (step_pend == 0) cpu_step_done = 1'b1;
        end
        if (cpu_step) step_pend = step_delay;
    end

    // GPR file
    logic [31:0] gpr [16];
    assign reg_rd_val = gpr[reg_sel];
    always @(posedge clk) if (reg_wr_en) gpr[reg_sel] <= reg_wr_val;

    // memory model: acks in the mem_delay-th cycle of a request (never if <0)
    int          mem_delay = 1;
    int          mcnt = 0;
    logic [31:0] mem_fill = '0;
    logic [31:0] memarr [256];
    bit          mwritten [256];
    logic [7:0]  midx;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!mem_access) begin
            mcnt = 0;
        end else if (mem_delay >= 0) begin
            mcnt++;
            if (mcnt == mem_delay) begin
                mem_ack = 1'b1;
                midx = mem_addr[9:2];
                if (mem_wr_en) begin
                    memarr[midx]   = mem_wr_data;
                    mwritten[midx] = 1'b1;
                end else begin
                    mem_rd_data = mwritten[midx] ? memarr[midx] : mem_fill;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; write_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        addr = a;
        @(negedge clk);
        v = read_data;
    endtask

    // writes CMD, raises req, drops it with ack, and records what it saw
    task automatic issue(input logic [31:0] cmd, input logic [31:0] exp_maddr, input logic exp_mwe);
        write_reg(2'd0, cmd);
        req = 1'b1;
        r_lat = -1; r_acks = 0; r_macc = 0; r_rwe = 0; r_steps = 0; r_addr_bad = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (mem_access) begin
                r_macc++;
                if (mem_addr !== exp_maddr || mem_wr_en !== exp_mwe) r_addr_bad = 1'b1;
            end
            if (reg_wr_en) r_rwe++;
            if (cpu_step) r_steps++;
            if (ack) begin
                r_lat = c; r_acks = 1; req = 1'b0;
                break;
            end
        end
        req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ack) r_acks++;
            if (reg_wr_en) r_rwe++;
            if (cpu_step) r_steps++;
            if (mem_access) r_macc++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        checks++; if (read_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_read_data: got %h expected %h", read_data, 32'h0); end
        checks++; if ({ack, cpu_halt_req, cpu_step, reg_wr_en, mem_access, mem_wr_en} !== 6'b0) begin errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", {ack, cpu_halt_req, cpu_step, reg_wr_en, mem_access, mem_wr_en}, 6'b0); end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), v);
            checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, v, 32'h0); end
        end
    endtask

    task automatic test_regs();
        logic [31:0] v;
        for (int i = 0; i < 5; i++) begin
            m_addr = (i == 0) ? 32'h100 : $urandom;
            m_data = (i == 0) ? 32'hdeadbeef : $urandom;
            write_reg(2'd1, m_addr);
            write_reg(2'd2, m_data);
            write_reg(2'd3, $urandom);
            read_reg(2'd1, v);
            checks++; if (v !== m_addr) begin errors++; $display("[TB] FAIL regs_addr: got %h expected %h", v, m_addr); end
            read_reg(2'd2, v);
            checks++; if (v !== m_data) begin errors++; $display("[TB] FAIL regs_data: got %h expected %h", v, m_data); end
            read_reg(2'd3, v);
            checks++; if (v !== m_result) begin errors++; $display("[TB] FAIL regs_result: got %h expected %h", v, m_result); end
        end
    endtask

    task automatic test_halt();
        logic [31:0] v;
        halt_delay = 5;
        issue(32'd0, 32'h0, 1'b0);
        checks++; if (r_lat !== halt_delay + 2) begin errors++; $display("[TB] FAIL halt_lat: got %0d expected %0d", r_lat, halt_delay + 2); end
        checks++; if (r_acks !== 1) begin errors++; $display("[TB] FAIL halt_acks: got %0d expected %0d", r_acks, 1); end
        checks++; if (cpu_halt_req !== 1'b1) begin errors++; $display("[TB] FAIL halt_req: got %b expected %b", cpu_halt_req, 1'b1); end
        read_reg(2'd0, v);
        checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL halt_status: got %h expected %h", v, 32'h1); end
    endtask

    task automatic test_rdmem();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            m_addr    = (i == 0) ? 32'h103 : $urandom;
            mem_delay = (i == 0) ? 3 : 1 + int'($urandom_range(5));
            mem_fill  = (i == 0) ? 32'h12345678 : $urandom;
            write_reg(2'd1, m_addr);
            issue(32'd5, {m_addr[31:2], 2'b00}, 1'b0);
            m_result = mem_fill;
            checks++; if (r_lat !== mem_delay + 2) begin errors++; $display("[TB] FAIL rdmem_lat: got %0d expected %0d", r_lat, mem_delay + 2); end
            checks++; if (r_macc !== mem_delay) begin errors++; $display("[TB] FAIL rdmem_access_cycles: got %0d expected %0d", r_macc, mem_delay); end
            checks++; if (r_addr_bad !== 1'b0) begin errors++; $display("[TB] FAIL rdmem_addr: got bad=%b expected bad=%b", r_addr_bad, 1'b0); end
            read_reg(2'd3, v);
            checks++; if (v !== m_result) begin errors++; $display("[TB] FAIL rdmem_result: got %h expected %h", v, m_result); end
            read_reg(2'd0, v);
            checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL rdmem_status: got %h expected %h", v, 32'h1); end
        end
    endtask

    task automatic test_wrmem();
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            m_addr    = $urandom;
            m_data    = $urandom;
            mem_delay = 1 + int'($urandom_range(5));
            write_reg(2'd1, m_addr);
            write_reg(2'd2, m_data);
            issue(32'd6, {m_addr[31:2], 2'b00}, 1'b1);
            checks++; if (r_lat !== mem_delay + 2) begin errors++; $display("[TB] FAIL wrmem_lat: got %0d expected %0d", r_lat, mem_delay + 2); end
            checks++; if (r_addr_bad !== 1'b0) begin errors++; $display("[TB] FAIL wrmem_addr: got bad=%b expected bad=%b", r_addr_bad, 1'b0); end
            mem_fill  = ~m_data;
            mem_delay = 2;
            issue(32'd5, {m_addr[31:2], 2'b00}, 1'b0);
            m_result = m_data;
            read_reg(2'd3, v);
            checks++; if (v !== m_result) begin errors++; $display("[TB] FAIL wrmem_readback: got %h expected %h", v, m_result); end
        end
    endtask

    task automatic test_regfile();
        logic [31:0] v;
        logic [3:0]  idx;
        for (int i = 0; i < 3; i++) begin
            idx    = 4'($urandom_range(15));
            m_addr = ($urandom & 32'hFFFF_FFF0) | {28'd0, idx};
            m_data = $urandom;
            write_reg(2'd1, m_addr);
            write_reg(2'd2, m_data);
            issue(32'd4, 32'h0, 1'b0);
            checks++; if (r_lat !== 3) begin errors++; $display("[TB] FAIL wrreg_lat: got %0d expected %0d", r_lat, 3); end
            checks++; if (r_rwe !== 1) begin errors++; $display("[TB] FAIL wrreg_pulses: got %0d expected %0d", r_rwe, 1); end
            m_result = m_data;
            write_reg(2'd2, $urandom);
            issue(32'd3, 32'h0, 1'b0);
            checks++; if (r_lat !== 3) begin errors++; $display("[TB] FAIL rdreg_lat: got %0d expected %0d", r_lat, 3); end
            read_reg(2'd3, v);
            checks++; if (v !== m_result) begin errors++; $display("[TB] FAIL rdreg_result: got %h expected %h", v, m_result); end
        end
    endtask

    task automatic test_step();
        for (int d = 1; d <= 4; d++) begin
            step_delay = d;
            issue(32'd2, 32'h0, 1'b0);
            checks++; if (r_steps !== 1) begin errors++; $display("[TB] FAIL step_pulses: got %0d expected %0d", r_steps, 1); end
            checks++; if (r_lat !== d + 3) begin errors++; $display("[TB] FAIL step_lat: got %0d expected %0d", r_lat, d + 3); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] v;
        logic [31:0] bad [6];
        issue(32'd1, 32'h0, 1'b0);
        checks++; if (r_lat !== 2) begin errors++; $display("[TB] FAIL run_lat: got %0d expected %0d", r_lat, 2); end
        checks++; if (cpu_halt_req !== 1'b0) begin errors++; $display("[TB] FAIL run_halt_req: got %b expected %b", cpu_halt_req, 1'b0); end
        bad[0] = 32'd4;
        bad[1] = 32'd2;
        bad[2] = 32'd3;
        bad[3] = 32'd7 + ($urandom % 9);
        bad[4] = {$urandom} | 32'h10;
        bad[5] = 32'h8000_0000;
        for (int i = 0; i < 6; i++) begin
            issue(bad[i], 32'h0, 1'b0);
            checks++; if (r_lat !== 2) begin errors++; $display("[TB] FAIL err_lat cmd=%h: got %0d expected %0d", bad[i], r_lat, 2); end
            checks++; if (r_rwe + r_steps + r_macc !== 0) begin errors++; $display("[TB] FAIL err_side_effect cmd=%h: got %0d expected %0d", bad[i], r_rwe + r_steps + r_macc, 0); end
            checks++; if (cpu_halt_req !== 1'b0) begin errors++; $display("[TB] FAIL err_halt_req cmd=%h: got %b expected %b", bad[i], cpu_halt_req, 1'b0); end
            read_reg(2'd0, v);
            checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL err_status cmd=%h: got %h expected %h", bad[i], v, 32'h4); end
        end
        read_reg(2'd3, v);
        checks++; if (v !== m_result) begin errors++; $display("[TB] FAIL err_result_kept: got %h expected %h", v, m_result); end
        issue(32'd1, 32'h0, 1'b0);
        read_reg(2'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL err_cleared: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        halt_delay = 2;
        issue(32'd0, 32'h0, 1'b0);
        checks++; if (r_lat !== 4) begin errors++; $display("[TB] FAIL to_halt_lat: got %0d expected %0d", r_lat, 4); end
        m_addr = $urandom;
        write_reg(2'd1, m_addr);
        mem_delay = -1;
        issue(32'd6, {m_addr[31:2], 2'b00}, 1'b1);
        checks++; if (r_macc !== TO) begin errors++; $display("[TB] FAIL to_mem_access_cycles: got %0d expected %0d", r_macc, TO); end
        checks++; if (r_lat !== TO + 2) begin errors++; $display("[TB] FAIL to_mem_lat: got %0d expected %0d", r_lat, TO + 2); end
        read_reg(2'd0, v);
        checks++; if (v !== 32'h5) begin errors++; $display("[TB] FAIL to_mem_status: got %h expected %h", v, 32'h5); end
        // ack in the very last cycle beats the timeout
        mem_delay = TO;
        mem_fill  = $urandom;
        issue(32'd5, {m_addr[31:2], 2'b00}, 1'b0);
        m_result = mem_fill;
        checks++; if (r_lat !== TO + 2) begin errors++; $display("[TB] FAIL to_edge_lat: got %0d expected %0d", r_lat, TO + 2); end
        read_reg(2'd0, v);
        checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL to_edge_status: got %h expected %h", v, 32'h1); end
        read_reg(2'd3, v);
        checks++; if (v !== m_result) begin errors++; $display("[TB] FAIL to_edge_result: got %h expected %h", v, m_result); end
        // one cycle too late
        mem_delay = TO + 1;
        mem_fill  = ~mem_fill;
        issue(32'd5, {m_addr[31:2], 2'b00}, 1'b0);
        read_reg(2'd0, v);
        checks++; if (v !== 32'h5) begin errors++; $display("[TB] FAIL to_late_status: got %h expected %h", v, 32'h5); end
        read_reg(2'd3, v);
        checks++; if (v !== m_result) begin errors++; $display("[TB] FAIL to_late_result: got %h expected %h", v, m_result); end
        // halt that never completes
        issue(32'd1, 32'h0, 1'b0);
        halt_delay = 1000;
        issue(32'd0, 32'h0, 1'b0);
        checks++; if (r_lat !== TO + 2) begin errors++; $display("[TB] FAIL to_halt_timeout_lat: got %0d expected %0d", r_lat, TO + 2); end
        checks++; if (cpu_halt_req !== 1'b1) begin errors++; $display("[TB] FAIL to_halt_req_kept: got %b expected %b", cpu_halt_req, 1'b1); end
        read_reg(2'd0, v);
        checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL to_halt_status: got %h expected %h", v, 32'h4); end
        halt_delay = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rst_mid();
        logic [31:0] v;
        m_addr = $urandom;
        write_reg(2'd1, m_addr);
        mem_delay = -1;
        write_reg(2'd0, 32'd6);
        req = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (mem_access !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_access: got %b expected %b", mem_access, 1'b1); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({mem_access, mem_wr_en, ack, cpu_halt_req} !== 4'b0) begin errors++; $display("[TB] FAIL rst_async_outputs: got %b expected %b", {mem_access, mem_wr_en, ack, cpu_halt_req}, 4'b0); end
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_addr = '0; m_data = '0; m_result = '0;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), v);
            checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL rst_reg%0d: got %h expected %h", a, v, 32'h0); end
        end
        halt_delay = 3;
        issue(32'd0, 32'h0, 1'b0);
        checks++; if (r_lat !== 5) begin errors++; $display("[TB] FAIL rst_after_halt_lat: got %0d expected %0d", r_lat, 5); end
        mem_delay = 2;
        mem_fill  = $urandom;
        issue(32'd5, 32'h0, 1'b0);
        m_result = mem_fill;
        checks++; if (r_lat !== 4) begin errors++; $display("[TB] FAIL rst_after_mem_lat: got %0d expected %0d", r_lat, 4); end
        read_reg(2'd3, v);
        checks++; if (v !== m_result) begin errors++; $display("[TB] FAIL rst_after_mem_result: got %h expected %h", v, m_result); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_regs();
        test_halt();
        test_rdmem();
        test_wrmem();
        test_regfile();
        test_step();
        test_errors();
        test_timeout();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
